// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares one BRAM port among NumReq valid/ready requesters.
// Round-robin grant, optional burst lock, 1-cycle read/write response routing
// and a saturating contention counter.
//
// state     | meaning
// ST_RR     | round-robin search starting at ptr_q among valid requesters
// ST_LOCKED | grant pinned to owner_q until it sends a beat with lock=0
module bram_port_arbiter #(
  parameter int NumReq        = 4,
  parameter int DataWidth     = 16,
  parameter int Depth         = 1024,
  parameter int AddrWidth     = $clog2(Depth + 1),
  parameter int StallCntWidth = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NumReq-1:0]              req_valid_i,
  output logic [NumReq-1:0]              req_ready_o,
  input  logic [NumReq-1:0]              req_write_en_i,
  input  logic [NumReq-1:0]              req_lock_i,
  input  logic [NumReq*AddrWidth-1:0]    req_addr_i,
  input  logic [NumReq*DataWidth-1:0]    req_data_i,
  output logic [NumReq-1:0]              rsp_valid_o,
  output logic [DataWidth-1:0]           rsp_data_o,
  output logic                           mem_write_en_o,
  output logic [AddrWidth-1:0]           mem_addr_o,
  output logic [DataWidth-1:0]           mem_data_o,
  input  logic [DataWidth-1:0]           mem_data_i,
  output logic [StallCntWidth-1:0]       stall_count_o,
  input  logic                           assert_on_i
);

  localparam int PtrW = $clog2(NumReq);

  typedef enum logic {
    ST_RR,
    ST_LOCKED
  } state_t;

  state_t                   state_q, state_d;
  logic [PtrW-1:0]          ptr_q, ptr_d;
  logic [PtrW-1:0]          owner_q, owner_d;
  logic [NumReq-1:0]        rsp_valid_q, rsp_valid_d;
  logic [StallCntWidth-1:0] stall_q, stall_d;

  logic [PtrW-1:0]          hi_idx, lo_idx, grant_idx;
  logic                     hi_hit, lo_hit, grant_hit;
  logic                     accept;
  logic                     contend;

  // Round-robin candidates: lowest valid index at/above ptr_q, else lowest overall.
  always_comb begin
    hi_idx = '0;
    hi_hit = 1'b0;
    lo_idx = '0;
    lo_hit = 1'b0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (req_valid_i[k]) begin
        lo_idx = PtrW'(k);
        lo_hit = 1'b1;
        if (k >= int'(ptr_q)) begin
          hi_idx = PtrW'(k);
          hi_hit = 1'b1;
        end
      end
    end
  end

  // Grant selection, next-state, memory port drive and stall accounting.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    grant_idx = hi_hit ? hi_idx : lo_idx;
    grant_hit = hi_hit | lo_hit;

    // A locked owner that goes idle leaves the port idle; others just wait.
    if (state_q == ST_LOCKED) begin
      grant_idx = owner_q;
      grant_hit = req_valid_i[owner_q];
    end

    accept                 = grant_hit & ~rst_i;
    req_ready_o            = '0;
    req_ready_o[grant_idx] = accept;

    if (accept) begin
      if (req_lock_i[grant_idx]) begin
        state_d = ST_LOCKED;
        owner_d = grant_idx;
      end else begin
        state_d = ST_RR;
        ptr_d   = (int'(grant_idx) == NumReq - 1) ? '0 : grant_idx + 1'b1;
      end
    end

    mem_write_en_o = accept & req_write_en_i[grant_idx];
    mem_addr_o     = accept ? req_addr_i[grant_idx*AddrWidth +: AddrWidth] : '0;
    mem_data_o     = accept ? req_data_i[grant_idx*DataWidth +: DataWidth] : '0;

    rsp_valid_d = req_ready_o;

    contend = |(req_valid_i & ~req_ready_o);
    stall_d = (contend && !(&stall_q)) ? stall_q + 1'b1 : stall_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RR;
      ptr_q       <= '0;
      owner_q     <= '0;
      rsp_valid_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      rsp_valid_q <= rsp_valid_d;
      stall_q     <= stall_d;
    end
  end

  // The response strobe is masked during reset so a read in flight at the
  // reset edge never reaches its requester.
  assign rsp_valid_o   = rsp_valid_q & ~{NumReq{rst_i}};
  assign rsp_data_o    = mem_data_i;
  assign stall_count_o = stall_q;

  // Protocol sanity checks, enabled at run time.
  always_ff @(posedge clk_i) begin
    if (assert_on_i && !rst_i) begin
      assert ($onehot0(req_ready_o)) else $error("req_ready_o not one-hot");
      assert ($onehot0(rsp_valid_o)) else $error("rsp_valid_o not one-hot");
      assert (!accept || (int'(mem_addr_o) < Depth)) else $error("address out of range");
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: queue-based requesters, behavioural BRAM,
// reference arbitration model and a response scoreboard.
module tb_bram_port_arbiter;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;
  localparam int AW    = $clog2(DEPTH + 1);
  localparam int SMAX  = 65535;
  localparam int SMAX4 = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   v, we, lk;
  logic [AW-1:0]  a [N];
  logic [DW-1:0]  d [N];
  logic [N*AW-1:0] addr_flat;
  logic [N*DW-1:0] data_flat;

  logic [N-1:0]   rdy, rsp_v;
  logic [DW-1:0]  rsp_d, mem_wd;
  logic           mem_we;
  logic [AW-1:0]  mem_a;
  logic [DW-1:0]  mem_rd = '0;
  logic [15:0]    stall;

  logic [N-1:0]   s_rdy, s_rsp_v;
  logic [DW-1:0]  s_rsp_d, s_wd;
  logic           s_we;
  logic [AW-1:0]  s_a;
  logic [3:0]     s_stall;

  always_comb begin
    addr_flat = '0;
    data_flat = '0;
    for (int k = 0; k < N; k++) begin
      addr_flat[k*AW +: AW] = a[k];
      data_flat[k*DW +: DW] = d[k];
    end
  end

  bram_port_arbiter #(.NumReq(N), .DataWidth(DW), .Depth(DEPTH), .StallCntWidth(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v), .req_ready_o(rdy),
    .req_write_en_i(we), .req_lock_i(lk), .req_addr_i(addr_flat), .req_data_i(data_flat),
    .rsp_valid_o(rsp_v), .rsp_data_o(rsp_d), .mem_write_en_o(mem_we), .mem_addr_o(mem_a),
    .mem_data_o(mem_wd), .mem_data_i(mem_rd), .stall_count_o(stall), .assert_on_i(1'b1));

  bram_port_arbiter #(.NumReq(N), .DataWidth(DW), .Depth(DEPTH), .StallCntWidth(4)) dut_sat (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v), .req_ready_o(s_rdy),
    .req_write_en_i(we), .req_lock_i(lk), .req_addr_i(addr_flat), .req_data_i(data_flat),
    .rsp_valid_o(s_rsp_v), .rsp_data_o(s_rsp_d), .mem_write_en_o(s_we), .mem_addr_o(s_a),
    .mem_data_o(s_wd), .mem_data_i(mem_rd), .stall_count_o(s_stall), .assert_on_i(1'b1));

  // Behavioural write-first BRAM with registered read data.
  logic [DW-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (mem_we) begin
      bram[mem_a] <= mem_wd;
      mem_rd      <= mem_wd;
    end else begin
      mem_rd <= bram[mem_a];
    end
  end

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;
  always @(posedge clk) cyc_n++;

  task automatic check(string nm, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc_n);
    end
  endtask

  // Reference model state.
  int            m_ptr = 0, m_owner = 0, m_stall = 0;
  bit            m_lock = 0;
  logic [DW-1:0] ref_mem [DEPTH];

  typedef struct {
    int            cyc;
    int            idx;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: grant per round-robin/lock rules, push expected responses.
  always @(negedge clk) begin
    int            g;
    logic [N-1:0]  exp_rdy;
    logic [DW-1:0] ed;
    check("stall_count", 64'(stall), 64'(m_stall));
    check("stall_sat", 64'(s_stall), 64'((m_stall > SMAX4) ? SMAX4 : m_stall));
    if (rst) begin
      check("ready_in_reset", 64'(rdy), 64'(0));
      check("we_in_reset", 64'(mem_we), 64'(0));
      m_ptr = 0; m_lock = 0; m_owner = 0; m_stall = 0;
    end else begin
      g = -1;
      if (m_lock) begin
        if (v[m_owner]) g = m_owner;
      end else begin
        for (int i = 0; i < N; i++)
          if (g < 0 && v[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      end
      exp_rdy = (g >= 0) ? N'(1 << g) : '0;
      check("ready", 64'(rdy), 64'(exp_rdy));
      check("mem_we", 64'(mem_we), (g >= 0) ? 64'(we[g]) : 64'(0));
      check("mem_addr", 64'(mem_a), (g >= 0) ? 64'(a[g]) : 64'(0));
      check("mem_data", 64'(mem_wd), (g >= 0) ? 64'(d[g]) : 64'(0));
      if (g >= 0) begin
        ed = we[g] ? d[g] : ref_mem[a[g]];
        if (we[g]) ref_mem[a[g]] = d[g];
        exp_q.push_back('{cyc_n, g, ed});
        if (lk[g]) begin
          m_lock = 1; m_owner = g;
        end else begin
          m_lock = 0; m_ptr = (g + 1) % N;
        end
      end
      if ((v & ~exp_rdy) != '0 && m_stall < SMAX) m_stall++;
    end
  end

  // Response monitor: one-cycle-later strobe and data for each accepted beat.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("rsp_in_reset", 64'(rsp_v), 64'(0));
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc_n) void'(exp_q.pop_front());
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc_n - 1) begin
      e = exp_q.pop_front();
      check("rsp_valid", 64'(rsp_v), 64'(1 << e.idx));
      check("rsp_data", 64'(rsp_d), 64'(e.data));
    end else begin
      check("rsp_idle", 64'(rsp_v), 64'(0));
    end
  end

  // Requester models: each holds a queue of beats, presents the head after its
  // gap, and pops it once it has been accepted.
  typedef struct {
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            gap;
  } beat_t;
  beat_t        bq [N][$];
  logic [N-1:0] rs;

  initial begin
    forever begin
      @(negedge clk);
      rs = rdy;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (rs[k] && bq[k].size() > 0) void'(bq[k].pop_front());
        v[k] = 1'b0; we[k] = 1'b0; lk[k] = 1'b0; a[k] = '0; d[k] = '0;
        if (bq[k].size() > 0) begin
          if (bq[k][0].gap > 0) begin
            bq[k][0].gap = bq[k][0].gap - 1;
          end else begin
            v[k]  = 1'b1;
            we[k] = bq[k][0].we;
            lk[k] = bq[k][0].lock;
            a[k]  = bq[k][0].addr;
            d[k]  = bq[k][0].data;
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic beat_t mk(logic w, logic l, int ad, logic [DW-1:0] dt, int gp);
    beat_t b;
    b.we = w; b.lock = l; b.addr = AW'(ad); b.data = dt; b.gap = gp;
    return b;
  endfunction

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (bq[k].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain();
    int n = 0;
    while (!all_empty() && n < 3000) begin
      cyc();
      n++;
    end
    if (!all_empty()) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got pending beats expected none (cycle %0d)", cyc_n);
      for (int k = 0; k < N; k++) bq[k].delete();
    end
    cyc();
    cyc();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    v = '0; we = '0; lk = '0;
    for (int k = 0; k < N; k++) begin a[k] = '0; d[k] = '0; end
    for (int i = 0; i < DEPTH; i++) begin bram[i] = '0; ref_mem[i] = '0; end
    cyc();
    cyc();
    rst = 1'b0;

    // Single requester write then read-back.
    bq[2].push_back(mk(1'b1, 1'b0, 5, 16'hBEEF, 0));
    bq[2].push_back(mk(1'b0, 1'b0, 5, 16'h0000, 0));
    drain();

    // All four requesters contending from reset.
    do_reset();
    for (int k = 0; k < N; k++)
      for (int j = 0; j < 2; j++) bq[k].push_back(mk(1'b0, 1'b0, k + 4 * j, '0, 0));
    drain();

    // Lock burst from requester 1 with requesters 0 and 3 waiting.
    do_reset();
    bq[0].push_back(mk(1'b1, 1'b0, 7, 16'h1234, 0));
    drain();
    bq[1].push_back(mk(1'b1, 1'b1, 8, 16'hA001, 0));
    bq[1].push_back(mk(1'b1, 1'b1, 9, 16'hA002, 0));
    bq[1].push_back(mk(1'b0, 1'b0, 8, 16'h0000, 0));
    bq[0].push_back(mk(1'b0, 1'b0, 9, 16'h0000, 0));
    bq[3].push_back(mk(1'b0, 1'b0, 7, 16'h0000, 0));
    drain();

    // Locked owner goes idle for two cycles while requester 0 waits.
    do_reset();
    bq[2].push_back(mk(1'b1, 1'b1, 10, 16'h5555, 0));
    bq[2].push_back(mk(1'b0, 1'b0, 10, 16'h0000, 2));
    bq[0].push_back(mk(1'b0, 1'b0, 5, 16'h0000, 1));
    drain();

    // Reset in the cycle after a read is accepted.
    do_reset();
    bq[3].push_back(mk(1'b0, 1'b0, 5, 16'h0000, 0));
    n = 0;
    while (bq[3].size() > 0 && n < 100) begin
      cyc();
      n++;
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bq[2].push_back(mk(1'b0, 1'b0, 5, 16'h0000, 0));
    bq[1].push_back(mk(1'b0, 1'b0, 7, 16'h0000, 0));
    drain();

    // Twenty contended cycles behind a lock: the 4-bit counter pins at 15.
    do_reset();
    bq[0].push_back(mk(1'b0, 1'b1, 3, 16'h0000, 0));
    bq[0].push_back(mk(1'b0, 1'b0, 3, 16'h0000, 20));
    bq[1].push_back(mk(1'b0, 1'b0, 4, 16'h0000, 1));
    drain();

    // Randomized traffic; every requester ends with an unlocked beat.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < N; k++) begin
        int nb = int'($urandom_range(20, 40));
        for (int j = 0; j < nb; j++) begin
          logic l = ($urandom_range(0, 3) == 0) && (j != nb - 1);
          bq[k].push_back(mk(1'($urandom_range(0, 1)), l, int'($urandom_range(0, 15)),
                             16'($urandom), int'($urandom_range(0, 2))));
        end
      end
      drain();
    end

    cyc();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
